// File: rtl/ct_sysio_mc_top.sv
// Multi-core system I/O hub: registers per-core interrupt/debug/status signals, samples the system counter and APB base,
// runs the L2 flush handshake FSM and qualifies the CPU no-op indication. The optional macro SYSIO_SYSCNT_GRAY_EN takes a gray-coded system counter.
module ct_sysio_mc_top #(
    parameter int NUM_CORES    = 2,
    parameter int CNT_W        = 64,
    parameter int APB_BASE_LSB = 27,
    parameter int NOOP_CYC     = 4
) (
    input  logic                   forever_cpuclk,
    input  logic                   cpurst,
    input  logic                   axim_clk_en,
    input  logic [CNT_W-1:0]       pad_cpu_sys_cnt,
    input  logic [39:0]            pad_cpu_apb_base,
    input  logic                   pad_cpu_l2cache_flush_req,
    input  logic                   l2c_sysio_flush_done,
    input  logic                   l2c_sysio_flush_idle,
    input  logic                   ciu_xx_no_op,
    input  logic [NUM_CORES-1:0]   clint_ms_int,
    input  logic [NUM_CORES-1:0]   clint_mt_int,
    input  logic [NUM_CORES-1:0]   clint_ss_int,
    input  logic [NUM_CORES-1:0]   clint_st_int,
    input  logic [NUM_CORES-1:0]   plic_me_int,
    input  logic [NUM_CORES-1:0]   plic_se_int,
    input  logic [NUM_CORES-1:0]   pad_dbgrq_b,
    input  logic [NUM_CORES-1:0]   pad_dbg_mask,
    input  logic [2*NUM_CORES-1:0] piu_sysio_lpmd_b,
    input  logic [2*NUM_CORES-1:0] piu_sysio_jdb_pm,
    output logic [NUM_CORES-1:0]   sysio_piu_ms_int,
    output logic [NUM_CORES-1:0]   sysio_piu_mt_int,
    output logic [NUM_CORES-1:0]   sysio_piu_ss_int,
    output logic [NUM_CORES-1:0]   sysio_piu_st_int,
    output logic [NUM_CORES-1:0]   sysio_piu_me_int,
    output logic [NUM_CORES-1:0]   sysio_piu_se_int,
    output logic [NUM_CORES-1:0]   sysio_piu_dbgrq_b,
    output logic [NUM_CORES-1:0]   sysio_had_dbg_mask,
    output logic [2*NUM_CORES-1:0] core_pad_lpmd_b,
    output logic [2*NUM_CORES-1:0] core_pad_jdb_pm,
    output logic [CNT_W-1:0]       sysio_xx_time,
    output logic [39:0]            sysio_xx_apb_base,
    output logic                   sysio_l2c_flush_req,
    output logic                   cpu_pad_l2cache_flush_done,
    output logic                   cpu_pad_no_op
);

    typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_DONE} flush_st_e;

    localparam logic [39:0] APB_MASK = ~((40'd1 << APB_BASE_LSB) - 40'd1);
    localparam logic [3:0]  NOOP_MAX = 4'(NOOP_CYC);

    logic [6*NUM_CORES-1:0] int_q;
    logic [NUM_CORES-1:0]   dbgrq_meta_q, dbgrq_sync_q, dbg_mask_q;
    logic [2*NUM_CORES-1:0] lpmd_b_q, jdb_pm_q;
    logic [CNT_W-1:0]       sys_cnt_bin, time_q;
    logic [39:0]            apb_base_q;
    flush_st_e              st_q, st_d;
    logic [3:0]             noop_cnt_q, noop_cnt_d;
    logic                   noop_cond;

`ifdef SYSIO_SYSCNT_GRAY_EN
    // Gray to binary: each bit is the parity of all gray bits at or above it.
    for (genvar i = 0; i < CNT_W; i++) begin : g_gray2bin
        assign sys_cnt_bin[i] = ^pad_cpu_sys_cnt[CNT_W-1:i];
    end
`else
    assign sys_cnt_bin = pad_cpu_sys_cnt;
`endif

    always_ff @(posedge forever_cpuclk or posedge cpurst) begin
        if (cpurst) begin
            int_q        <= '0;
            dbgrq_meta_q <= '1;
            dbgrq_sync_q <= '1;
            dbg_mask_q   <= '0;
            lpmd_b_q     <= '1;
            jdb_pm_q     <= '0;
            time_q       <= '0;
            apb_base_q   <= '0;
            st_q         <= ST_IDLE;
            noop_cnt_q   <= '0;
        end else begin
            int_q        <= {clint_ms_int, clint_mt_int, clint_ss_int,
                             clint_st_int, plic_me_int, plic_se_int};
            dbgrq_meta_q <= pad_dbgrq_b;
            dbgrq_sync_q <= dbgrq_meta_q;
            dbg_mask_q   <= pad_dbg_mask;
            lpmd_b_q     <= piu_sysio_lpmd_b;
            jdb_pm_q     <= piu_sysio_jdb_pm;
            if (axim_clk_en) begin
                time_q     <= sys_cnt_bin;
                apb_base_q <= pad_cpu_apb_base & APB_MASK;
            end
            st_q         <= st_d;
            noop_cnt_q   <= noop_cnt_d;
        end
    end

    always_comb begin
        st_d = st_q;
        if (axim_clk_en) begin
            unique case (st_q)
                ST_IDLE: if (pad_cpu_l2cache_flush_req)  st_d = ST_REQ;
                ST_REQ:  if (l2c_sysio_flush_done)       st_d = ST_DONE;
                ST_DONE: if (!pad_cpu_l2cache_flush_req) st_d = ST_IDLE;
                default: st_d = ST_IDLE;
            endcase
        end
    end

    // Quiescence only counts while no flush handshake is in progress.
    assign noop_cond = ciu_xx_no_op & l2c_sysio_flush_idle & (st_q == ST_IDLE);

    always_comb begin
        noop_cnt_d = noop_cnt_q;
        if (axim_clk_en) begin
            if (!noop_cond)
                noop_cnt_d = '0;
            else if (noop_cnt_q != NOOP_MAX)
                noop_cnt_d = noop_cnt_q + 4'd1;
        end
    end

    assign {sysio_piu_ms_int, sysio_piu_mt_int, sysio_piu_ss_int,
            sysio_piu_st_int, sysio_piu_me_int, sysio_piu_se_int} = int_q;
    assign sysio_piu_dbgrq_b          = dbgrq_sync_q;
    assign sysio_had_dbg_mask         = dbg_mask_q;
    assign core_pad_lpmd_b            = lpmd_b_q;
    assign core_pad_jdb_pm            = jdb_pm_q;
    assign sysio_xx_time              = time_q;
    assign sysio_xx_apb_base          = apb_base_q;
    assign sysio_l2c_flush_req        = (st_q == ST_REQ);
    assign cpu_pad_l2cache_flush_done = (st_q == ST_DONE);
    assign cpu_pad_no_op              = (noop_cnt_q == NOOP_MAX);

endmodule

// File: tb/tb_ct_sysio_mc_top.sv
// Bench for ct_sysio_mc_top: directed scenarios followed by random traffic, all checked against a behavioural model.
module tb_ct_sysio_mc_top;
    localparam int NC   = 2;
    localparam int CW   = 64;
    localparam int ALSB = 27;
    localparam int NOOP = 4;

    logic clk = 1'b0;
    logic rst;
    logic en;
    logic [CW-1:0] cnt;
    logic [39:0] apb;
    logic freq, fdone, fidle, cnoop;
    logic [NC-1:0] ms, mt, ss, st, me, se, dbgrq_b, mask;
    logic [2*NC-1:0] lpmd, jdb;
    logic [NC-1:0] o_ms, o_mt, o_ss, o_st, o_me, o_se, o_dbgrq_b, o_mask;
    logic [2*NC-1:0] o_lpmd, o_jdb;
    logic [CW-1:0] o_time;
    logic [39:0] o_apb;
    logic o_req, o_done, o_noop;

    int n_cmp = 0;
    int n_bad = 0;

    // Behavioural model state: what the outputs should show after the latest edge.
    logic [6*NC-1:0] m_ints;
    logic [NC-1:0]   m_dbg1, m_dbg2, m_mask;
    logic [2*NC-1:0] m_lpmd, m_jdb;
    logic [CW-1:0]   m_time;
    logic [39:0]     m_apb;
    bit              m_busy, m_fin;
    int              m_run;

    ct_sysio_mc_top #(.NUM_CORES(NC), .CNT_W(CW), .APB_BASE_LSB(ALSB), .NOOP_CYC(NOOP)) dut (
        .forever_cpuclk(clk), .cpurst(rst), .axim_clk_en(en),
        .pad_cpu_sys_cnt(cnt), .pad_cpu_apb_base(apb),
        .pad_cpu_l2cache_flush_req(freq), .l2c_sysio_flush_done(fdone),
        .l2c_sysio_flush_idle(fidle), .ciu_xx_no_op(cnoop),
        .clint_ms_int(ms), .clint_mt_int(mt), .clint_ss_int(ss), .clint_st_int(st),
        .plic_me_int(me), .plic_se_int(se),
        .pad_dbgrq_b(dbgrq_b), .pad_dbg_mask(mask),
        .piu_sysio_lpmd_b(lpmd), .piu_sysio_jdb_pm(jdb),
        .sysio_piu_ms_int(o_ms), .sysio_piu_mt_int(o_mt), .sysio_piu_ss_int(o_ss),
        .sysio_piu_st_int(o_st), .sysio_piu_me_int(o_me), .sysio_piu_se_int(o_se),
        .sysio_piu_dbgrq_b(o_dbgrq_b), .sysio_had_dbg_mask(o_mask),
        .core_pad_lpmd_b(o_lpmd), .core_pad_jdb_pm(o_jdb),
        .sysio_xx_time(o_time), .sysio_xx_apb_base(o_apb),
        .sysio_l2c_flush_req(o_req), .cpu_pad_l2cache_flush_done(o_done),
        .cpu_pad_no_op(o_noop)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
        end
    endtask

    function automatic logic [CW-1:0] gray2bin(input logic [CW-1:0] g);
        logic [CW-1:0] b = g;
        for (int k = 1; k < CW; k++) b ^= (g >> k);
        return b;
    endfunction

    task automatic model_reset();
        m_ints = '0; m_dbg1 = '1; m_dbg2 = '1; m_mask = '0;
        m_lpmd = '1; m_jdb = '0; m_time = '0; m_apb = '0;
        m_busy = 0; m_fin = 0; m_run = 0;
    endtask

    // Advance the model by one edge using the inputs currently driven.
    task automatic model_step();
        bit quiet = cnoop && fidle && !m_busy && !m_fin;
        m_ints = {ms, mt, ss, st, me, se};
        m_dbg2 = m_dbg1;
        m_dbg1 = dbgrq_b;
        m_mask = mask;
        m_lpmd = lpmd;
        m_jdb  = jdb;
        if (en) begin
`ifdef SYSIO_SYSCNT_GRAY_EN
            m_time = gray2bin(cnt);
`else
            m_time = cnt;
`endif
            m_apb = {apb[39:ALSB], {ALSB{1'b0}}};
            m_run = quiet ? ((m_run < NOOP) ? m_run + 1 : NOOP) : 0;
            if (!m_busy && !m_fin && freq) m_busy = 1;
            else if (m_busy && fdone) begin m_busy = 0; m_fin = 1; end
            else if (m_fin && !freq) m_fin = 0;
        end
    endtask

    task automatic check_all();
        chk("ints", 64'({o_ms, o_mt, o_ss, o_st, o_me, o_se}), 64'(m_ints));
        chk("dbgrq_b", 64'(o_dbgrq_b), 64'(m_dbg2));
        chk("dbg_mask", 64'(o_mask), 64'(m_mask));
        chk("lpmd_b", 64'(o_lpmd), 64'(m_lpmd));
        chk("jdb_pm", 64'(o_jdb), 64'(m_jdb));
        chk("time", 64'(o_time), 64'(m_time));
        chk("apb_base", 64'(o_apb), 64'(m_apb));
        chk("flush_req", 64'(o_req), 64'(m_busy));
        chk("flush_done", 64'(o_done), 64'(m_fin));
        chk("no_op", 64'(o_noop), 64'(m_run == NOOP));
    endtask

    // Inputs are changed on the falling edge; outputs are checked on the following falling edge.
    task automatic tick();
        model_step();
        @(posedge clk);
        @(negedge clk);
        check_all();
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; cnt = '0; apb = '0; freq = 0; fdone = 0; fidle = 0; cnoop = 0;
        {ms, mt, ss, st, me, se} = '0; dbgrq_b = '1; mask = '0; lpmd = '1; jdb = '0;
        model_reset();
        repeat (3) @(negedge clk);
        check_all();
        chk("rst_dbgrq_b", 64'(o_dbgrq_b), 64'h3);
        chk("rst_lpmd_b", 64'(o_lpmd), 64'hf);
        rst = 1'b0;

        me = 2'b10;
        tick();
        chk("me_int", 64'(o_me), 64'h2);
        me = 2'b00;

        en = 1; cnt = 64'h1234; apb = 40'hAB_CDEF_1234;
        tick();
        en = 0; cnt = 64'h1235;
        tick();
`ifdef SYSIO_SYSCNT_GRAY_EN
        chk("time_hold", o_time, gray2bin(64'h1234));
        en = 1; cnt = 64'h3;
        tick();
        chk("time_gray", o_time, 64'h2);
`else
        chk("time_hold", o_time, 64'h1234);
`endif
        chk("apb_lsb", 64'(o_apb), 64'h00AB_C800_0000 & 64'hFF_F800_0000);

        en = 1; fidle = 1; freq = 1;
        tick();
        chk("req_rise", 64'(o_req), 64'h1);
        freq = 0;
        tick();
        chk("req_held", 64'(o_req), 64'h1);
        fdone = 1;
        tick();
        chk("done_rise", 64'({o_req, o_done}), 64'h1);
        fdone = 0;
        tick();
        chk("done_fall", 64'({o_req, o_done}), 64'h0);

        cnoop = 1;
        repeat (3) tick();
        chk("noop_early", 64'(o_noop), 64'h0);
        tick();
        chk("noop_rise", 64'(o_noop), 64'h1);
        fidle = 0;
        tick();
        chk("noop_fall", 64'(o_noop), 64'h0);
        fidle = 1;
        repeat (3) tick();
        chk("noop_re3", 64'(o_noop), 64'h0);
        tick();
        chk("noop_re4", 64'(o_noop), 64'h1);

        freq = 1;
        tick();
        chk("req_pre_rst", 64'(o_req), 64'h1);
        #2 rst = 1'b1;
        #1;
        model_reset();
        chk("rst_req", 64'({o_req, o_done, o_noop}), 64'h0);
        @(negedge clk);
        rst = 1'b0;
        tick();
        chk("req_after_rst", 64'(o_req), 64'h1);

        for (int i = 0; i < 1500; i++) begin
            en    = ($urandom_range(0, 2) != 0);
            cnt   = {$urandom(), $urandom()};
            apb   = {8'($urandom()), $urandom()};
            if ($urandom_range(0, 19) == 0) freq = ~freq;
            fdone = ($urandom_range(0, 3) == 0);
            fidle = ($urandom_range(0, 7) != 0);
            cnoop = ($urandom_range(0, 7) != 0);
            {ms, mt, ss, st, me, se} = 12'($urandom());
            dbgrq_b = 2'($urandom()); mask = 2'($urandom());
            lpmd = 4'($urandom()); jdb = 4'($urandom());
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
